fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised successor to the single-register fetch unit: a decoupled instruction-fetch stage with a valid/ready instruction-memory request port, an in-order response port, and a DEPTH-entry prefetch FIFO. Issues sequential PC+4 requests, pairs each returned instruction with its PC, and hands {pc, inst} to decode over a valid/ready handshake. Decode stalls by deasserting inst_ready; jal/jalr target selection moves upstream into a single redirect input. Redirect flushes all buffered and in-flight fetches.

## Interface
- XLEN, 32, PC/address width.
- ILEN, 32, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, >= 2.
- RESET_PC, 0, first fetch address after reset; bits [1:0] must be 0.

Ports:
- clock  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- redirect_valid  in  1  flush and restart fetch at redirect_target.
- redirect_target  in  XLEN  new PC; bits [1:0] ignored and treated as 0.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address (fetch_pc).
- imem_rsp_valid  in  1  one response per accepted request, in order, latency >= 1.
- imem_rsp_data  in  ILEN  instruction word.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts head.
- inst_pc  out  XLEN  PC of head.
- inst_data  out  ILEN  instruction at head.

## Operation
- State: fetch_pc, rsp_pc, FIFO (count 0..DEPTH), pending (accepted requests not yet responded, 0..DEPTH), drop (stale responses still to be discarded, <= pending).
- Reset: fetch_pc = rsp_pc = RESET_PC; count = pending = drop = 0; imem_req_valid = 0 and inst_valid = 0 while reset is high.
- imem_req_valid = count + (pending - drop) < DEPTH. Depends only on registers, never on imem_req_ready or redirect_valid. Credit check guarantees the FIFO never overflows.
- Request fire (valid & ready): fetch_pc += 4, pending += 1.
- Response with drop > 0: discard; drop -= 1, pending -= 1.
- Response with drop = 0: push {rsp_pc, data}; rsp_pc += 4; pending -= 1.
- Response with pending = 0 is a protocol error; ignore it.
- Pop on inst_valid & inst_ready. Push and pop in the same cycle are both performed; count unchanged.
- Redirect cycle: FIFO cleared; fetch_pc = rsp_pc = target & ~3.
  - drop = pending + req_fire - rsp_valid, so every response still owed is stale.
  - A response arriving in the redirect cycle is discarded.
  - A request firing in the redirect cycle carries the old address and is counted stale.
  - inst_valid is forced low combinationally, so no pop occurs.
- Redirect beats stall: it takes effect regardless of inst_ready.
- PC arithmetic is modulo 2^XLEN; 0xFFFFFFFC + 4 wraps to 0.
- Reset mid-operation discards everything, including outstanding memory responses. The memory side must be reset together with this block.

## Timing
- First request: first cycle after reset deasserts, addr = RESET_PC.
- Response to inst_valid latency: 1 cycle (registered FIFO, no bypass).
- Redirect to first request at the new target: next cycle, provided credit is available.
- Redirect to first new instruction: memory latency L + 1 cycles after the request fires.
- Throughput: 1 instruction/cycle sustained when DEPTH >= L + 1 and inst_ready stays high.

## Test plan
- Reset, RESET_PC = 0x100, memory L = 1, always ready, inst_ready = 1 -> requests 0x100, 0x104, ... on consecutive cycles; inst_pc 0x100, 0x104, ... one per cycle from cycle 2, data matching memory contents.
- inst_ready = 0 for 10 cycles, DEPTH = 4, L = 1:
  - exactly 4 requests are accepted, then imem_req_valid drops;
  - FIFO holds PCs 0x0..0xC;
  - on release, PCs are delivered in order with no gap or duplicate.
- Memory L = 3 with 3 requests in flight; redirect to 0x203 -> all 3 old responses are discarded; next request addr = 0x200; first inst_pc = 0x200; no old PC ever appears on inst_pc.
- Redirect in the same cycle as a request fire and a response arrival -> fired request and arriving response both discarded; drop counts correctly; the next delivered PC is the target.
- Redirect to 0xFFFFFFF8 -> delivered PCs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Random imem_req_ready, random response latency, random inst_ready and random redirects vs. a reference model -> delivered {pc, inst} stream matches; FIFO never overflows; pending never exceeds DEPTH.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory request/response
// channels and the decode-side instruction handshake.
interface fetch_queue_if #(
  parameter int XLEN = 32,
  parameter int ILEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst_pc;
  logic [ILEN-1:0] inst_data;

  // fetch unit side
  modport master (
    input  redirect_valid, redirect_target, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data
  );

  // memory / decode / redirect source side
  modport slave (
    output redirect_valid, redirect_target, imem_req_ready,
           imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data
  );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: sequential PC+4 requests, in-order responses
// paired with their PC in a DEPTH-entry prefetch FIFO, redirect flushes
// everything buffered and marks every still-owed response as stale.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              ILEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   pending;
  logic [CW-1:0]   drop;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [ILEN-1:0] inst_mem [DEPTH];

  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic [CW-1:0]   pending_next;
  logic [XLEN-1:0] target_pc;

  // Live (non-stale) requests plus buffered entries must never exceed DEPTH,
  // so every response we keep has a FIFO slot waiting for it.
  assign credit_used = {1'b0, count} + {1'b0, pending - drop};

  assign bus.imem_req_valid = ~reset & (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;

  assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_take  = bus.imem_rsp_valid & (pending != '0);
  assign push      = rsp_take & (drop == '0) & ~bus.redirect_valid;

  assign bus.inst_valid = ~reset & ~bus.redirect_valid & (count != '0);
  assign bus.inst_pc    = pc_mem[rd_ptr];
  assign bus.inst_data  = inst_mem[rd_ptr];
  assign pop            = bus.inst_valid & bus.inst_ready;

  assign pending_next = pending + CW'(req_fire) - CW'(rsp_take);
  assign target_pc    = {bus.redirect_target[XLEN-1:2], 2'b00};

  // Control state: PCs, FIFO pointers, outstanding/stale response counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      pending  <= '0;
      drop     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= target_pc;
      rsp_pc   <= target_pc;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pending  <= pending_next;
      drop     <= pending_next;
    end else begin
      pending <= pending_next;
      if (req_fire)
        fetch_pc <= fetch_pc + XLEN'(4);
      if (rsp_take && drop != '0)
        drop <= drop - CW'(1);
      if (push) begin
        rsp_pc <= rsp_pc + XLEN'(4);
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr]   <= rsp_pc;
      inst_mem[wr_ptr] <= bus.imem_rsp_data;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed + random bench for fetch_queue with a behavioural memory and an
// expected-{pc,inst} scoreboard.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;

  logic clock = 1'b0;
  logic reset;

  fetch_queue_if #(.XLEN(32), .ILEN(32)) bus ();

  fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic [63:0] sb[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] pop_log[$];
  int          last_due = 0;

  logic [31:0] model_pc;
  int          rdy_pct = 100;
  int          ird_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        redir_v = 1'b0;
  logic [31:0] redir_t = '0;
  int          fires = 0;
  int          pops = 0;
  int          first_fire_cyc = -1;
  int          first_pop_cyc = -1;
  logic        last_fire, last_rsp;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at negedge, evaluate the edge, advance.
  task automatic tick();
    logic fire, rsp, pop;
    int lat, due;
    logic [63:0] e;
    if (!reset && mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memf(mq_addr[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    bus.imem_req_ready  = ($urandom_range(99) < rdy_pct);
    bus.inst_ready      = ($urandom_range(99) < ird_pct);
    bus.redirect_valid  = redir_v;
    bus.redirect_target = redir_t;
    #1;
    fire = bus.imem_req_valid & bus.imem_req_ready;
    rsp  = bus.imem_rsp_valid;
    pop  = bus.inst_valid & bus.inst_ready;
    last_fire = fire;
    last_rsp  = rsp;
    if (reset) begin
      chk("reset_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("reset_inst_valid", 64'(bus.inst_valid), 64'd0);
      sb.delete();
      mq_addr.delete();
      mq_due.delete();
      model_pc = RESET_PC;
      last_due = cyc;
    end else begin
      if (redir_v)
        chk("inst_valid_on_redirect", 64'(bus.inst_valid), 64'd0);
      if (fire) begin
        chk("req_addr", 64'(bus.imem_req_addr), 64'(model_pc));
        lat = $urandom_range(lat_max, lat_min);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq_addr.push_back(bus.imem_req_addr);
        mq_due.push_back(due);
        if (!redir_v) sb.push_back({model_pc, memf(model_pc)});
        model_pc = model_pc + 32'd4;
        fires++;
        if (first_fire_cyc < 0) first_fire_cyc = cyc;
      end
      if (rsp) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (pop) begin
        chk("pop_has_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("inst_pc_data", {bus.inst_pc, bus.inst_data}, e);
        end
        pop_log.push_back(bus.inst_pc);
        pops++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
      if (redir_v) begin
        sb.delete();
        model_pc = {redir_t[31:2], 2'b00};
      end
      chk("fifo_bound", 64'(sb.size() <= DEPTH), 64'd1);
      chk("pending_bound", 64'(mq_addr.size() <= DEPTH), 64'd1);
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_target = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.inst_ready = 1'b0;
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("first_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("first_req_addr", 64'(bus.imem_req_addr), 64'(RESET_PC));

    // Streaming from reset, L=1, always ready.
    fires = 0; pops = 0;
    for (int i = 0; i < 20; i++) tick();
    chk("first_inst_latency", 64'(first_pop_cyc - first_fire_cyc), 64'd2);
    chk("stream_pop_count", 64'(pops), 64'd18);

    // Stall decode for 10 cycles after redirecting to 0.
    redir_v = 1'b1; redir_t = 32'h0; ird_pct = 0;
    tick();
    redir_v = 1'b0; fires = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_fires", 64'(fires), 64'd4);
    chk("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("stall_head_valid", 64'(bus.inst_valid), 64'd1);
    chk("stall_head_pc", 64'(bus.inst_pc), 64'h0);
    ird_pct = 100; pops = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("release_no_gap", 64'(pops), 64'd4);

    // Latency 3 with requests in flight, redirect to unaligned 0x203.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10; i++) tick();
    redir_v = 1'b1; redir_t = 32'h203;
    pop_log.delete();
    tick();
    redir_v = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("l3_delivered", 64'(pop_log.size() >= 3), 64'd1);
    foreach (pop_log[i])
      chk("l3_pc_seq", 64'(pop_log[i]), 64'(32'h200 + 32'(4 * i)));

    // Redirect coinciding with a request fire and a response arrival.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 6; i++) tick();
    redir_v = 1'b1; redir_t = 32'h4000;
    pop_log.delete();
    tick();
    redir_v = 1'b0;
    chk("same_cycle_fire_rsp", {62'd0, last_fire, last_rsp}, 64'd3);
    for (int i = 0; i < 8; i++) tick();
    chk("same_cycle_delivered", 64'(pop_log.size() != 0), 64'd1);
    if (pop_log.size() != 0)
      chk("same_cycle_first_pc", 64'(pop_log[0]), 64'h4000);

    // PC wrap at the top of the address space.
    redir_v = 1'b1; redir_t = 32'hFFFF_FFF8;
    pop_log.delete();
    tick();
    redir_v = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("wrap_delivered", 64'(pop_log.size() >= 3), 64'd1);
    if (pop_log.size() >= 3) begin
      chk("wrap_pc0", 64'(pop_log[0]), 64'hFFFF_FFF8);
      chk("wrap_pc1", 64'(pop_log[1]), 64'hFFFF_FFFC);
      chk("wrap_pc2", 64'(pop_log[2]), 64'h0);
    end

    // Random ready, latency and redirects.
    rdy_pct = 70; ird_pct = 60; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      redir_v = ($urandom_range(99) < 3);
      redir_t = $urandom;
      tick();
    end
    redir_v = 1'b0;

    // Drain: stop requesting, let memory and FIFO empty.
    rdy_pct = 0; ird_pct = 100;
    for (int i = 0; i < 200 && (sb.size() != 0 || mq_addr.size() != 0); i++) tick();
    tick();
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
    chk("drain_inst_valid", 64'(bus.inst_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
